// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Bus bundle between the two requesters, the arbiter and the memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Port C (pipeline MEM stage)
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_stall;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    // Port D (DMA / debug)
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_stall, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_stall, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Fixed-priority data-memory arbiter (C over D) with D starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_C    = 2'd1,
        R_D    = 2'd2
    } resp_owner_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    resp_owner_t       resp_owner_q, resp_owner_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;

    logic              force_d;
    logic              c_gnt;
    logic              d_gnt;
    logic              mem_we_sel;
    logic [ADDR_W-1:0] mem_addr_sel;
    logic [DATA_W-1:0] mem_wdata_sel;

    // Grant decision: D only wins over an active C once it has waited STARVE_MAX cycles.
    always_comb begin
        force_d = (starve_cnt_q == STARVE_LIMIT);
        d_gnt   = bus.d_req & (~bus.c_req | force_d);
        c_gnt   = bus.c_req & ~d_gnt;
    end

    always_comb begin
        mem_we_sel    = 1'b0;
        mem_addr_sel  = '0;
        mem_wdata_sel = '0;
        if (c_gnt) begin
            mem_we_sel    = bus.c_we;
            mem_addr_sel  = bus.c_addr;
            mem_wdata_sel = bus.c_wdata;
        end else if (d_gnt) begin
            mem_we_sel    = bus.d_we;
            mem_addr_sel  = bus.d_addr;
            mem_wdata_sel = bus.d_wdata;
        end
    end

    always_comb begin
        resp_owner_d = R_NONE;
        if (c_gnt && !bus.c_we) begin
            resp_owner_d = R_C;
        end else if (d_gnt && !bus.d_we) begin
            resp_owner_d = R_D;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (d_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (bus.d_req && (starve_cnt_q != STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_owner_q <= R_NONE;
            starve_cnt_q <= 4'd0;
        end else begin
            resp_owner_q <= resp_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign bus.c_gnt     = c_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.c_stall   = bus.c_req & ~c_gnt;

    assign bus.mem_en    = c_gnt | d_gnt;
    assign bus.mem_we    = mem_we_sel;
    assign bus.mem_addr  = mem_addr_sel;
    assign bus.mem_wdata = mem_wdata_sel;

    // Read data is steered by who owned the load issued last cycle; zero otherwise.
    assign bus.c_rvalid  = (resp_owner_q == R_C);
    assign bus.d_rvalid  = (resp_owner_q == R_D);
    assign bus.c_rdata   = bus.c_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;

endmodule

`default_nettype wire
